// File: rtl/alu_instruction_encoder.sv
// alu_instruction_encoder
// Checks ALU instruction requests for legality, packs legal ones into the
// 32-bit word format read by alu_instruction_decoder, and buffers them in a
// 2-entry in-order FIFO. Illegal requests are consumed, dropped and reported.
module alu_instruction_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_const_c,
  input  logic [2:0]  in_alu_op,
  input  logic        in_alu_form,
  input  logic [1:0]  in_alu_vec_perci,
  input  logic [31:0] in_constant,
  input  logic [3:0]  in_a_select,
  input  logic [3:0]  in_b_select,
  input  logic [3:0]  in_c_select,
  input  logic [3:0]  in_d_select,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count,
  input  logic        err_clear
);

  logic [31:0] fifo_mem [0:1];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  occupancy;

  logic        accept;
  logic        bad_form;
  logic        bad_constant;
  logic        illegal;
  logic [1:0]  cause;
  logic        push;
  logic        pop;
  logic [31:0] packed_word;

  // Handshake, legality checks and word packing for the current request.
  // A full FIFO refuses input regardless of out_ready so in_ready has no
  // combinational path from the downstream side.
  always_comb begin
    in_ready     = (occupancy != 2'd2);
    out_valid    = (occupancy != 2'd0);
    accept       = in_valid & in_ready;
    bad_form     = in_const_c & in_alu_form;
    bad_constant = in_const_c & (|in_constant[31:18]);
    illegal      = bad_form | bad_constant;
    cause        = bad_form ? 2'b01 : 2'b10;
    push         = accept & ~illegal;
    pop          = out_valid & out_ready;
    packed_word  = {3'b000, in_const_c, in_alu_op, in_alu_form, in_alu_vec_perci,
                    6'd0, in_a_select, in_b_select, in_c_select, in_d_select};
    if (in_const_c) begin
      packed_word[21:16] = in_constant[17:12];
      packed_word[11:0]  = in_constant[11:0];
    end
    out_instruction = out_valid ? fifo_mem[rd_ptr] : 32'd0;
  end

  // FIFO pointers and occupancy; push and pop together keep occupancy steady.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        occupancy <= occupancy + 2'd1;
      end else if (pop && !push) begin
        occupancy <= occupancy - 2'd1;
      end
    end
  end

  // FIFO storage; contents are only visible through out_instruction when valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= 32'd0;
      fifo_mem[1] <= 32'd0;
    end else if (push) begin
      fifo_mem[wr_ptr] <= packed_word;
    end
  end

  // Error reporting: one-cycle pulse after a dropped request, sticky cause and
  // saturating count. A simultaneous clear beats the update but not the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_code  <= 2'b00;
      err_count <= 8'd0;
    end else begin
      err_valid <= accept & illegal;
      if (err_clear) begin
        err_code  <= 2'b00;
        err_count <= 8'd0;
      end else if (accept && illegal) begin
        err_code <= cause;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_instruction_encoder.sv
// Testbench for alu_instruction_encoder: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_alu_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_const_c;
  logic [2:0]  in_alu_op;
  logic        in_alu_form;
  logic [1:0]  in_alu_vec_perci;
  logic [31:0] in_constant;
  logic [3:0]  in_a_select;
  logic [3:0]  in_b_select;
  logic [3:0]  in_c_select;
  logic [3:0]  in_d_select;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic        err_clear;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q [$];
  logic        exp_err_valid;
  logic [1:0]  exp_err_code;
  int          exp_err_count;

  alu_instruction_encoder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_const_c(in_const_c), .in_alu_op(in_alu_op), .in_alu_form(in_alu_form),
    .in_alu_vec_perci(in_alu_vec_perci), .in_constant(in_constant),
    .in_a_select(in_a_select), .in_b_select(in_b_select),
    .in_c_select(in_c_select), .in_d_select(in_d_select),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .err_valid(err_valid), .err_code(err_code), .err_count(err_count),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference word built with plain arithmetic from the field positions.
  function automatic logic [31:0] modelWord();
    int unsigned w;
    w = (int'(in_const_c) << 28) + (int'(in_alu_op) << 25) + (int'(in_alu_form) << 24)
      + (int'(in_alu_vec_perci) << 22) + (int'(in_a_select) << 12);
    if (in_const_c)
      w = w + (((in_constant / 4096) % 64) * 65536) + (in_constant % 4096);
    else
      w = w + int'(in_b_select) * 256 + int'(in_c_select) * 16 + int'(in_d_select);
    return w;
  endfunction

  task automatic modelReset();
    exp_q.delete();
    exp_err_valid = 1'b0;
    exp_err_code  = 2'b00;
    exp_err_count = 0;
  endtask

  task automatic checkState();
    checkOutput("in_ready", in_ready, (exp_q.size() < 2));
    checkOutput("out_valid", out_valid, (exp_q.size() != 0));
    checkOutput("out_instruction", out_instruction, (exp_q.size() != 0) ? exp_q[0] : 32'd0);
    checkOutput("err_valid", err_valid, exp_err_valid);
    checkOutput("err_code", err_code, exp_err_code);
    checkOutput("err_count", err_count, exp_err_count);
  endtask

  // Advance the model across the coming rising edge using the applied inputs.
  task automatic modelEdge();
    bit accept, bad_form, bad_const, pop;
    accept    = in_valid && (exp_q.size() < 2);
    bad_form  = in_const_c && in_alu_form;
    bad_const = in_const_c && (in_constant >= 32'h0004_0000);
    pop       = (exp_q.size() != 0) && out_ready;
    if (pop) void'(exp_q.pop_front());
    if (accept && !bad_form && !bad_const) exp_q.push_back(modelWord());
    exp_err_valid = accept && (bad_form || bad_const);
    if (err_clear) begin
      exp_err_code  = 2'b00;
      exp_err_count = 0;
    end else if (exp_err_valid) begin
      exp_err_code = bad_form ? 2'b01 : 2'b10;
      if (exp_err_count < 255) exp_err_count++;
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, check, then advance.
  task automatic applyStimulus(input logic v, input logic cc, input logic [2:0] op,
                               input logic form, input logic [1:0] vec, input logic [31:0] k,
                               input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                               input logic [3:0] d, input logic ordy, input logic clr);
    in_valid = v; in_const_c = cc; in_alu_op = op; in_alu_form = form;
    in_alu_vec_perci = vec; in_constant = k; in_a_select = a; in_b_select = b;
    in_c_select = c; in_d_select = d; out_ready = ordy; err_clear = clr;
    #1;
    checkState();
    modelEdge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 32'd0, 4'd0, 4'd0, 4'd0, 4'd0, ordy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_const_c = 1'b0; in_alu_op = 3'd0; in_alu_form = 1'b0;
    in_alu_vec_perci = 2'd0; in_constant = 32'd0; in_a_select = 4'd0; in_b_select = 4'd0;
    in_c_select = 4'd0; in_d_select = 4'd0; out_ready = 1'b0; err_clear = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checkState();
    reset = 1'b0;

    // Register-form word appears one cycle later, for exactly one cycle.
    applyStimulus(1'b1, 1'b0, 3'b101, 1'b1, 2'b10, 32'd0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
    checkOutput("reg_word", out_instruction, 32'h0B80_1234);
    idle(1'b1);
    checkOutput("reg_word_popped", out_valid, 1'b0);

    // Constant-form word ignores the b/c/d selects.
    applyStimulus(1'b1, 1'b1, 3'b010, 1'b0, 2'b00, 32'h0003_4ABC, 4'd5, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
    checkOutput("const_word", out_instruction, 32'h1434_5ABC);
    idle(1'b1);

    // Backpressure: three back-to-back requests with the output stalled.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 3'(i), 1'b0, 2'd1, 32'd0, 4'(i), 4'd6, 4'd7, 4'd8, 1'b0, 1'b0);
    checkOutput("bp_full_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 3'd2, 1'b0, 2'd1, 32'd0, 4'd2, 4'd6, 4'd7, 4'd8, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    checkOutput("bp_drained", out_valid, 1'b0);

    // Illegal requests: form bit in constant form, then oversized constant.
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b1, 2'd0, 32'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    checkOutput("ill_form_pulse", err_valid, 1'b1);
    checkOutput("ill_form_code", err_code, 2'b01);
    checkOutput("ill_form_count", err_count, 8'd1);
    checkOutput("ill_form_no_word", out_valid, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b0, 2'd0, 32'h0004_0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    checkOutput("ill_const_code", err_code, 2'b10);
    checkOutput("ill_const_count", err_count, 8'd2);
    idle(1'b1);
    checkOutput("err_pulse_one_cycle", err_valid, 1'b0);
    checkOutput("err_code_holds", err_code, 2'b10);

    // Saturation after 300 illegal requests.
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 2'd0, 32'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    idle(1'b1);
    checkOutput("err_saturated", err_count, 8'hFF);

    // Clear coincident with an error: clear wins, pulse still fires.
    applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 2'd0, 32'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    checkOutput("clr_pulse", err_valid, 1'b1);
    checkOutput("clr_count", err_count, 8'd0);
    checkOutput("clr_code", err_code, 2'b00);

    // Reset with two words buffered and a nonzero error count.
    applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 2'd0, 32'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd1, 1'b0, 2'd0, 32'd0, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd4, 1'b1, 2'd3, 32'd0, 4'd8, 4'd7, 4'd6, 4'd5, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_err_count", err_count, 8'd0);
    checkOutput("rst_err_valid", err_valid, 1'b0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b101, 1'b1, 2'b10, 32'd0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
    checkOutput("post_rst_word", out_instruction, 32'h0B80_1234);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] k;
      k = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0003_FFFF);
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom),
                    1'($urandom_range(0, 3) == 0), 2'($urandom), k,
                    4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
